// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: control bits, decoded instruction and
// issue-queue entry layout.
package ooo_pkg;

    localparam int unsigned TAG_W = 6;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        ctrl_t           ctrl;
    } inst_t;

    typedef struct packed {
        logic             valid;
        inst_t            inst;
        logic [TAG_W-1:0] src1_tag;
        logic [TAG_W-1:0] src2_tag;
        logic             src1_rdy;
        logic             src2_rdy;
        logic [TAG_W-1:0] dst_tag;
    } iq_entry_t;

    // An entry may issue once it holds an instruction with both operands ready.
    function automatic logic entry_eligible(input iq_entry_t e);
        return e.valid & e.src1_rdy & e.src2_rdy;
    endfunction

endpackage

// File: rtl/issue_queue_sched_if.sv
// Dispatch / writeback / issue bundle between rename, the issue queue and the ALU.
interface issue_queue_sched_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 6
);
    import ooo_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    inst_t            disp_inst;
    logic [TAG_W-1:0] disp_src1_tag;
    logic [TAG_W-1:0] disp_src2_tag;
    logic             disp_src1_rdy;
    logic             disp_src2_rdy;
    logic [TAG_W-1:0] disp_dst_tag;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic             issue_valid;
    logic             issue_ready;
    inst_t            issue_inst;
    logic [TAG_W-1:0] issue_src1_tag;
    logic [TAG_W-1:0] issue_src2_tag;
    logic [TAG_W-1:0] issue_dst_tag;
    logic [CW-1:0]    count;

    modport master (
        output flush, disp_valid, disp_inst, disp_src1_tag, disp_src2_tag,
               disp_src1_rdy, disp_src2_rdy, disp_dst_tag, wb_valid, wb_tag,
               issue_ready,
        input  disp_ready, issue_valid, issue_inst, issue_src1_tag,
               issue_src2_tag, issue_dst_tag, count
    );

    modport slave (
        input  flush, disp_valid, disp_inst, disp_src1_tag, disp_src2_tag,
               disp_src1_rdy, disp_src2_rdy, disp_dst_tag, wb_valid, wb_tag,
               issue_ready,
        output disp_ready, issue_valid, issue_inst, issue_src1_tag,
               issue_src2_tag, issue_dst_tag, count
    );

endinterface

// File: rtl/iq_oldest_select.sv
// Oldest-first picker: lowest set bit of the eligible vector wins.
module iq_oldest_select #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] grant,
    output logic [IW-1:0]    index,
    output logic             found
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = IW'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue_sched.sv
// Collapsing issue queue with tag-broadcast wakeup and oldest-first
// single-issue scheduling toward the integer ALU.
module issue_queue_sched #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    issue_queue_sched_if.slave bus
);
    import ooo_pkg::*;

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned ETW = ooo_pkg::TAG_W;

    iq_entry_t        q     [DEPTH];
    iq_entry_t        q_n   [DEPTH];
    iq_entry_t        woken [DEPTH+1];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_n;
    logic [CW-1:0]    tail;
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] grant;
    logic [IW-1:0]    sel_idx;
    logic             any_elig;
    iq_entry_t        sel_ent;
    iq_entry_t        new_ent;
    logic             issue_fire;
    logic             disp_fire;
    logic [ETW-1:0]   wb_tag_e;

    always_comb begin
        elig = '0;
        for (int i = 0; i < DEPTH; i++) elig[i] = entry_eligible(q[i]);
    end

    iq_oldest_select #(.DEPTH(DEPTH), .IW(IW)) u_select (
        .eligible (elig),
        .grant    (grant),
        .index    (sel_idx),
        .found    (any_elig)
    );

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < DEPTH; i++) if (grant[i]) sel_ent = q[i];
    end

    // Issue outputs are combinational from registered entries, so they hold while stalled.
    assign bus.disp_ready     = (count_q < CW'(DEPTH));
    assign bus.issue_valid    = any_elig & ~bus.flush;
    assign bus.issue_inst     = sel_ent.inst;
    assign bus.issue_src1_tag = TAG_W'(sel_ent.src1_tag);
    assign bus.issue_src2_tag = TAG_W'(sel_ent.src2_tag);
    assign bus.issue_dst_tag  = TAG_W'(sel_ent.dst_tag);
    assign bus.count          = count_q;

    assign issue_fire = bus.issue_valid & bus.issue_ready;
    assign disp_fire  = bus.disp_valid & bus.disp_ready & ~bus.flush;
    assign wb_tag_e   = ETW'(bus.wb_tag);

    // Incoming entry, with same-cycle writeback bypass on either source.
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.inst     = bus.disp_inst;
        new_ent.src1_tag = ETW'(bus.disp_src1_tag);
        new_ent.src2_tag = ETW'(bus.disp_src2_tag);
        new_ent.dst_tag  = ETW'(bus.disp_dst_tag);
        new_ent.src1_rdy = bus.disp_src1_rdy |
                           (bus.wb_valid && (ETW'(bus.disp_src1_tag) == wb_tag_e));
        new_ent.src2_rdy = bus.disp_src2_rdy |
                           (bus.wb_valid && (ETW'(bus.disp_src2_tag) == wb_tag_e));
    end

    // Wakeup, then collapse above the issued slot, then append at the new tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = q[i];
            if (bus.wb_valid && q[i].valid) begin
                if (q[i].src1_tag == wb_tag_e) woken[i].src1_rdy = 1'b1;
                if (q[i].src2_tag == wb_tag_e) woken[i].src2_rdy = 1'b1;
            end
        end
        woken[DEPTH] = '0;

        tail    = count_q - CW'(issue_fire);
        count_n = tail + CW'(disp_fire);

        for (int i = 0; i < DEPTH; i++) begin
            q_n[i] = (issue_fire && (IW'(i) >= sel_idx)) ? woken[i+1] : woken[i];
            if (disp_fire && (CW'(i) == tail)) q_n[i] = new_ent;
        end

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) q_n[i] = '0;
            count_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            count_q <= count_n;
            for (int i = 0; i < DEPTH; i++) q[i] <= q_n[i];
        end
    end

endmodule
